// File: rtl/dna_search_pkg.sv
// Shared types and the masked pattern compare for the DNA search sequencer.
// Build option: DNA_SEARCH_WILDCARD_EN adds per-base don't-care masking.
package dna_search_pkg;

    localparam int DEF_MAX_PAT_BASES = 16;
    localparam int PAT_LIMIT         = 64;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Compares the lowest len bases; masked bases always agree.
    function automatic logic masked_eq(
        input logic [2*PAT_LIMIT-1:0] win,
        input logic [2*PAT_LIMIT-1:0] pat,
        input logic [PAT_LIMIT-1:0]   mask,
        input logic [6:0]             len
    );
        logic eq;
        eq = 1'b1;
        for (int i = 0; i < PAT_LIMIT; i++) begin
            if ((7'(i) < len) && !mask[i] &&
                (win[2*i +: 2] != pat[2*i +: 2]))
                eq = 1'b0;
        end
        return eq;
    endfunction

endpackage

// File: rtl/dna_search_sequencer_window_cmp.sv
// Sliding base window with length- and mask-aware comparison against the pattern.
// match_hit reflects the window as it will be after the current shift.
module dna_window_cmp
    import dna_search_pkg::*;
#(
    parameter int MAX_PAT_BASES = DEF_MAX_PAT_BASES,
    parameter int PL_W          = $clog2(MAX_PAT_BASES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       shift,
    input  logic [1:0]                 base,
    input  logic [PL_W-1:0]            pat_len,
    input  logic [2*MAX_PAT_BASES-1:0] pattern,
    input  logic [MAX_PAT_BASES-1:0]   mask,
    output logic                       match_hit
);

    logic [2*MAX_PAT_BASES-1:0] window;
    logic [2*MAX_PAT_BASES-1:0] window_nx;

    // Oldest base sits at slot 0; the newest lands at slot pat_len-1.
    always_comb begin
        window_nx = window >> 2;
        for (int i = 0; i < MAX_PAT_BASES; i++) begin
            if (PL_W'(i + 1) == pat_len)
                window_nx[2*i +: 2] = base;
        end
    end

    assign match_hit = masked_eq((2*PAT_LIMIT)'(window_nx),
                                 (2*PAT_LIMIT)'(pattern),
                                 PAT_LIMIT'(mask),
                                 7'(pat_len));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            window <= '0;
        else if (clear)
            window <= '0;
        else if (shift)
            window <= window_nx;
    end

endmodule

// File: rtl/dna_search_sequencer.sv
// Sequences one DNA pattern search over a valid/ready base stream.
// Build option: DNA_SEARCH_WILDCARD_EN adds the cfg_mask don't-care input.
module dna_search_sequencer
    import dna_search_pkg::*;
#(
    parameter int MAX_PAT_BASES = DEF_MAX_PAT_BASES,
    parameter int SEQ_LEN_W     = 24,
    parameter int CNT_W         = 16,
    parameter int PL_W          = $clog2(MAX_PAT_BASES + 1)
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [2*MAX_PAT_BASES-1:0] cfg_pattern,
    input  logic [PL_W-1:0]            cfg_pat_len,
    input  logic [SEQ_LEN_W-1:0]       cfg_seq_len,
`ifdef DNA_SEARCH_WILDCARD_EN
    input  logic [MAX_PAT_BASES-1:0]   cfg_mask,
`endif
    input  logic                       start,
    input  logic                       abort,
    input  logic [1:0]                 s_base_data,
    input  logic                       s_base_valid,
    output logic                       s_base_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       aborted,
    output logic [CNT_W-1:0]           match_count,
    output logic [SEQ_LEN_W-1:0]       first_idx
);

    state_t state, state_nx;

    logic [2*MAX_PAT_BASES-1:0] pat_r;
    logic [MAX_PAT_BASES-1:0]   mask_r;
    logic [MAX_PAT_BASES-1:0]   mask_in;
    logic [PL_W-1:0]            pat_len_r;
    logic [SEQ_LEN_W-1:0]       seq_len_r;
    logic [SEQ_LEN_W-1:0]       base_cnt;
    logic [SEQ_LEN_W-1:0]       n;
    logic                       cfg_bad;
    logic                       launch;
    logic                       accept;
    logic                       last;
    logic                       match_hit;

`ifdef DNA_SEARCH_WILDCARD_EN
    assign mask_in = cfg_mask;
`else
    assign mask_in = '0;
`endif

    assign cfg_bad = (cfg_pat_len == '0) ||
                     (cfg_pat_len > PL_W'(MAX_PAT_BASES)) ||
                     (cfg_seq_len < SEQ_LEN_W'(cfg_pat_len));

    assign launch = start && (state != SCAN);
    assign accept = s_base_valid && (state == SCAN);
    assign n      = base_cnt + 1'b1;
    assign last   = accept && (n == seq_len_r);

    assign s_base_ready = (state == SCAN);
    assign busy         = (state == SCAN);
    assign done         = (state == DONE);

    dna_window_cmp #(
        .MAX_PAT_BASES (MAX_PAT_BASES),
        .PL_W          (PL_W)
    ) u_window (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .clear     (launch),
        .shift     (accept),
        .base      (s_base_data),
        .pat_len   (pat_len_r),
        .pattern   (pat_r),
        .mask      (mask_r),
        .match_hit (match_hit)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Abort has priority over completion and over any start in SCAN.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (start)
                    state_nx = cfg_bad ? DONE : SCAN;
            end
            SCAN: begin
                if (abort)
                    state_nx = IDLE;
                else if (last)
                    state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pat_r       <= '0;
            mask_r      <= '0;
            pat_len_r   <= '0;
            seq_len_r   <= '0;
            base_cnt    <= '0;
            err         <= 1'b0;
            aborted     <= 1'b0;
            match_count <= '0;
            first_idx   <= '1;
        end else if (launch) begin
            pat_r       <= cfg_pattern;
            mask_r      <= mask_in;
            pat_len_r   <= cfg_pat_len;
            seq_len_r   <= cfg_seq_len;
            base_cnt    <= '0;
            err         <= cfg_bad;
            aborted     <= 1'b0;
            match_count <= '0;
            first_idx   <= '1;
        end else if (state == SCAN) begin
            if (abort)
                aborted <= 1'b1;
            if (accept) begin
                base_cnt <= n;
                if (match_hit && (n >= SEQ_LEN_W'(pat_len_r))) begin
                    if (match_count != '1)
                        match_count <= match_count + 1'b1;
                    // All-ones is unreachable as a real index, so it marks "none yet".
                    if (first_idx == '1)
                        first_idx <= n - SEQ_LEN_W'(pat_len_r);
                end
            end
        end
    end

endmodule

// File: doc/dna_search_sequencer.md
Name: dna_search_sequencer

Overview:
Control FSM and sliding-window comparator that sequences one DNA pattern search. It sits behind the AXI4-Lite register slave of the DNASearcher_Small IP: config registers drive pattern, lengths and start; results feed the read-back registers.
It consumes a 2-bit-per-base reference stream over a valid/ready handshake, counts pattern occurrences and records the first match position.

Parameters:
MAX_PAT_BASES, 16, maximum pattern length in bases (pattern bus = 2*MAX_PAT_BASES bits).
SEQ_LEN_W, 24, width of sequence length and base index.
CNT_W, 16, width of the match counter.

Ports:
ACLK  in  1  clock.
ARESETN  in  1  asynchronous active-low reset.
cfg_pattern  in  2*MAX_PAT_BASES  pattern; base 0 in bits [1:0]; A=0 C=1 G=2 T=3.
cfg_pat_len  in  $clog2(MAX_PAT_BASES+1)  pattern length in bases.
cfg_seq_len  in  SEQ_LEN_W  number of reference bases to scan.
start  in  1  single-cycle start pulse.
abort  in  1  single-cycle abort pulse.
s_base_data  in  2  reference base.
s_base_valid  in  1  base valid.
s_base_ready  out  1  base ready.
busy  out  1  search in progress.
done  out  1  search complete (level).
err  out  1  illegal configuration.
aborted  out  1  last search was aborted.
match_count  out  CNT_W  occurrences found.
first_idx  out  SEQ_LEN_W  index of first base of first match; all-ones if none.

Behaviour:
- Interface decided: one clock ACLK; reset ARESETN is asynchronous, active-low.
- Reset: state IDLE; busy=0, done=0, err=0, aborted=0, s_base_ready=0, match_count=0, first_idx=all-ones; window and counters cleared.
- States: IDLE, SCAN, DONE.
- IDLE/DONE + start: latch cfg_* into shadow registers; clear count, first_idx, window, base counter, done, err, aborted.
  - If pat_len==0, pat_len>MAX_PAT_BASES or seq_len<pat_len: go to DONE next cycle with err=1; no bases accepted.
  - Otherwise go to SCAN.
- SCAN: s_base_ready=1. Base accepted when valid&&ready.
  - Accepted base shifts into window at position [pat_len-1]; oldest base drops out.
  - After an accept, n = bases accepted so far. If n>=pat_len and window[pat_len-1:0] equals pattern[pat_len-1:0]:
    - match_count increments, saturating at all-ones.
    - If first match, first_idx = n - pat_len.
  - Both updates are visible the cycle after the accepting edge (1-cycle latency).
  - When n reaches seq_len: s_base_ready drops that same edge (registered), next state DONE, busy=0, done=1.
- DONE: outputs held; done stays 1 until next start.
- busy=1 only in SCAN.
- start while in SCAN: ignored.
- abort in SCAN: go to IDLE next edge; s_base_ready=0; aborted=1; count and first_idx hold partial values; done=0.
  - If abort and start are both asserted, abort wins.
  - abort in IDLE/DONE: ignored.
- Overlapping matches are counted (ACA in ACACA = 2).
- Async reset mid-SCAN returns everything to reset values immediately; stream not drained.

Optional Feature:
DNA_SEARCH_WILDCARD_EN
- Defined: adds input cfg_mask [MAX_PAT_BASES-1:0]. A mask bit set makes that pattern base don't-care in the compare. The mask is shadowed at start.
- Undefined: port absent; all bases compared exactly.

Decomposition:
Package dna_search_pkg holds:
- base encoding enum (BASE_A..BASE_T)
- state enum (IDLE, SCAN, DONE)
- MAX_PAT_BASES default
- helper function for the masked compare of pat_len bases

One sub-module, dna_window_cmp: shift window plus combinational length/mask-aware equality, output match_hit.

Test Plan:
- Pattern ACG (len 3), seq ACGACGT (len 7), valid always high -> match_count=2, first_idx=0, done=1 after 7 accepts, busy low the cycle done rises.
- Pattern AA, seq AAAA -> overlapping count=3, first_idx=0.
- Pattern GT, seq ACAC -> count=0, first_idx=0xFFFFFF, done=1, err=0.
- pat_len=0, then pat_len=17, then seq_len=2 with pat_len=3 -> err=1, done=1, s_base_ready never high.
- Seq len 8, abort after 3 accepts -> aborted=1, done=0, s_base_ready=0 next cycle. A new start clears aborted and completes normally.
- Random valid gaps; start pulsed mid-SCAN -> results equal to the gap-free run; stray start has no effect. With DNA_SEARCH_WILDCARD_EN, pattern AxG on ACGATG -> count=2.
